// File: rtl/clk_div_meas.sv
// Measures the period and high time of a slow divided clock (sig_in) in clk cycles,
// reporting each completed rise-fall-rise measurement and flagging lock/timeout.
module clk_div_meas #(
  parameter int WIDTH    = 7,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

  state_t           state, state_next;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [WIDTH-1:0] cnt, cnt_next, cnt_inc;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] period_next, high_time_next;
  logic [MW-1:0]    match_cnt, match_next;
  logic             meas_valid_next, locked_next, timeout_next;
  logic             expire;

  // Two flops resolve metastability; the third gives the previous sample for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_reg     <= '0;
      match_cnt  <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      hi_reg     <= hi_next;
      match_cnt  <= match_next;
      period     <= period_next;
      high_time  <= high_time_next;
      meas_valid <= meas_valid_next;
      locked     <= locked_next;
      timeout    <= timeout_next;
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    hi_next         = hi_reg;
    match_next      = match_cnt;
    period_next     = period;
    high_time_next  = high_time;
    meas_valid_next = 1'b0;
    locked_next     = locked;
    timeout_next    = timeout;
    expire          = 1'b0;

    if (!enable) begin
      // Disabling wins over any edge or expiry seen on the same cycle.
      state_next   = IDLE;
      cnt_next     = '0;
      match_next   = '0;
      locked_next  = 1'b0;
      timeout_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_next = WAIT_RISE;
          cnt_next   = '0;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_next = HIGH;
            cnt_next   = WIDTH'(1);
          end
        end
        HIGH: begin
          if (fall) begin
            hi_next    = cnt;
            cnt_next   = cnt_inc;
            state_next = LOW;
          end else if (cnt == CNT_MAX) begin
            expire = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            period_next     = cnt;
            high_time_next  = hi_reg;
            meas_valid_next = 1'b1;
            cnt_next        = WIDTH'(1);
            state_next      = HIGH;
            if (cnt == period && hi_reg == high_time) begin
              if (match_cnt != LOCK_MAX) match_next = match_cnt + 1'b1;
            end else begin
              match_next = '0;
            end
            locked_next = (match_next == LOCK_MAX);
          end else if (cnt == CNT_MAX) begin
            expire = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: state_next = IDLE;
      endcase

      // Counter saturated without the awaited edge: abandon this measurement.
      if (expire) begin
        timeout_next = 1'b1;
        match_next   = '0;
        locked_next  = 1'b0;
        cnt_next     = '0;
        state_next   = WAIT_RISE;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_meas.sv
// Directed bench for clk_div_meas: lock, re-lock, minimum period, timeout, reset and enable cases.
module tb_clk_div_meas;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       sig_in;
  logic [6:0] period;
  logic [6:0] high_time;
  logic       meas_valid;
  logic       locked;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wave_start;
  int rise_cyc;
  int rel_cyc;

  int         mv_cyc[$];
  logic [6:0] mv_per[$];
  logic [6:0] mv_hi[$];
  logic       mv_lock[$];

  clk_div_meas #(.WIDTH(7), .LOCK_CNT(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Advance one clock and log any measurement pulse seen just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (meas_valid === 1'b1) begin
      mv_cyc.push_back(cyc);
      mv_per.push_back(period);
      mv_hi.push_back(high_time);
      mv_lock.push_back(locked);
    end
  endtask

  task automatic clear_log();
    mv_cyc.delete();
    mv_per.delete();
    mv_hi.delete();
    mv_lock.delete();
  endtask

  task automatic drive_wave(input int hi, input int lo, input int n);
    repeat (n) begin
      sig_in = 1'b1;
      repeat (hi) step();
      sig_in = 1'b0;
      repeat (lo) step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; sig_in = 1'b0;
    repeat (2) step();
    checks++;
    if ({period, high_time} !== 14'd0) begin
      errors++; $display("FAIL reset_data got %0d/%0d want 0/0", period, high_time);
    end
    checks++;
    if ({meas_valid, locked, timeout} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {meas_valid, locked, timeout});
    end
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (mv_cyc.size() != 0 || meas_valid !== 1'b0) begin
      errors++; $display("FAIL idle_no_meas got %0d want 0", mv_cyc.size());
    end
    $display("test_reset done");
  endtask

  task automatic test_lock_10_5();
    enable = 1'b1;
    repeat (3) step();
    clear_log();
    wave_start = cyc;
    drive_wave(5, 5, 6);
    checks++;
    if (mv_cyc.size() != 5) begin
      errors++; $display("FAIL lock10_count got %0d want 5", mv_cyc.size());
    end
    for (int j = 0; j < 5 && j < mv_cyc.size(); j++) begin
      checks++;
      if (mv_per[j] !== 7'd10 || mv_hi[j] !== 7'd5) begin
        errors++; $display("FAIL lock10_meas%0d got %0d/%0d want 10/5", j, mv_per[j], mv_hi[j]);
      end
      checks++;
      if (mv_cyc[j] != wave_start + 10 * (j + 1) + 3) begin
        errors++; $display("FAIL lock10_time%0d got %0d want %0d", j, mv_cyc[j], wave_start + 10 * (j + 1) + 3);
      end
      checks++;
      if (mv_lock[j] !== (j >= 3)) begin
        errors++; $display("FAIL lock10_locked%0d got %b want %b", j, mv_lock[j], (j >= 3));
      end
    end
    $display("test_lock_10_5 done: %0d measurements", mv_cyc.size());
  endtask

  task automatic test_switch_7_4();
    clear_log();
    wave_start = cyc;
    drive_wave(4, 3, 6);
    checks++;
    if (mv_cyc.size() != 6) begin
      errors++; $display("FAIL sw7_count got %0d want 6", mv_cyc.size());
    end
    for (int j = 0; j < 6 && j < mv_cyc.size(); j++) begin
      checks++;
      if (j == 0) begin
        if (mv_per[j] !== 7'd10 || mv_hi[j] !== 7'd5 || mv_lock[j] !== 1'b1) begin
          errors++; $display("FAIL sw7_last10 got %0d/%0d lock %b want 10/5 lock 1", mv_per[j], mv_hi[j], mv_lock[j]);
        end
      end else begin
        if (mv_per[j] !== 7'd7 || mv_hi[j] !== 7'd4 || mv_lock[j] !== (j >= 4)) begin
          errors++; $display("FAIL sw7_meas%0d got %0d/%0d lock %b want 7/4 lock %b",
                             j, mv_per[j], mv_hi[j], mv_lock[j], (j >= 4));
        end
      end
    end
    $display("test_switch_7_4 done: %0d measurements", mv_cyc.size());
  endtask

  task automatic test_period2();
    clear_log();
    wave_start = cyc;
    drive_wave(1, 1, 8);
    sig_in = 1'b1;
    rise_cyc = cyc;
    repeat (3) step();
    checks++;
    if (mv_cyc.size() != 9) begin
      errors++; $display("FAIL p2_count got %0d want 9", mv_cyc.size());
    end
    checks++;
    if (mv_cyc.size() > 0 && (mv_per[0] !== 7'd7 || mv_hi[0] !== 7'd4)) begin
      errors++; $display("FAIL p2_last7 got %0d/%0d want 7/4", mv_per[0], mv_hi[0]);
    end
    for (int j = 1; j < 9 && j < mv_cyc.size(); j++) begin
      checks++;
      if (mv_per[j] !== 7'd2 || mv_hi[j] !== 7'd1 || mv_lock[j] !== (j >= 4) ||
          mv_cyc[j] != wave_start + 2 * j + 3) begin
        errors++; $display("FAIL p2_meas%0d got %0d/%0d lock %b at %0d want 2/1 lock %b at %0d",
                           j, mv_per[j], mv_hi[j], mv_lock[j], mv_cyc[j], (j >= 4), wave_start + 2 * j + 3);
      end
    end
    $display("test_period2 done: %0d measurements", mv_cyc.size());
  endtask

  task automatic test_timeout();
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL to_prelock got %b want 1", locked);
    end
    clear_log();
    for (int i = 0; i < 300 && timeout !== 1'b1; i++) step();
    checks++;
    if (timeout !== 1'b1) begin
      errors++; $display("FAIL to_set got %b want 1 (bound expired)", timeout);
    end
    checks++;
    if (cyc != rise_cyc + 130) begin
      errors++; $display("FAIL to_time got %0d want %0d", cyc, rise_cyc + 130);
    end
    checks++;
    if (locked !== 1'b0 || mv_cyc.size() != 0) begin
      errors++; $display("FAIL to_side got lock %b meas %0d want lock 0 meas 0", locked, mv_cyc.size());
    end
    repeat (5) step();
    checks++;
    if (timeout !== 1'b1 || period !== 7'd2) begin
      errors++; $display("FAIL to_sticky got to %b period %0d want 1/2", timeout, period);
    end
    enable = 1'b0;
    step();
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL to_clear got %b want 0", timeout);
    end
    $display("test_timeout done at cycle %0d", cyc);
  endtask

  task automatic test_reset_mid_high();
    sig_in = 1'b0;
    enable = 1'b1;
    repeat (3) step();
    clear_log();
    drive_wave(5, 5, 3);
    sig_in = 1'b1;
    repeat (4) step();
    checks++;
    if (mv_cyc.size() != 3 || period !== 7'd10 || high_time !== 7'd5) begin
      errors++; $display("FAIL rst_pre got %0d meas %0d/%0d want 3 meas 10/5", mv_cyc.size(), period, high_time);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({period, high_time} !== 14'd0) begin
      errors++; $display("FAIL rst_async_data got %0d/%0d want 0/0", period, high_time);
    end
    checks++;
    if ({meas_valid, locked, timeout} !== 3'b000) begin
      errors++; $display("FAIL rst_async_flags got %b want 000", {meas_valid, locked, timeout});
    end
    repeat (2) step();
    reset = 1'b1;
    rel_cyc = cyc;
    clear_log();
    repeat (2) step();
    sig_in = 1'b0;
    repeat (5) step();
    sig_in = 1'b1;
    repeat (3) step();
    checks++;
    if (mv_cyc.size() != 1) begin
      errors++; $display("FAIL rst_restart_count got %0d want 1", mv_cyc.size());
    end else if (mv_cyc[0] != rel_cyc + 10 || mv_per[0] !== 7'd7 || mv_hi[0] !== 7'd2 || mv_lock[0] !== 1'b0) begin
      errors++; $display("FAIL rst_restart got %0d/%0d lock %b at %0d want 7/2 lock 0 at %0d",
                         mv_per[0], mv_hi[0], mv_lock[0], mv_cyc[0], rel_cyc + 10);
    end
    $display("test_reset_mid_high done");
  endtask

  task automatic test_enable_on_rise();
    repeat (2) step();
    sig_in = 1'b0;
    repeat (5) step();
    clear_log();
    sig_in = 1'b1;
    repeat (2) step();
    enable = 1'b0;
    step();
    checks++;
    if (meas_valid !== 1'b0 || mv_cyc.size() != 0) begin
      errors++; $display("FAIL en_rise_meas got %b want 0", meas_valid);
    end
    checks++;
    if (period !== 7'd7 || high_time !== 7'd2) begin
      errors++; $display("FAIL en_rise_hold got %0d/%0d want 7/2", period, high_time);
    end
    repeat (4) step();
    sig_in = 1'b0;
    repeat (5) step();
    sig_in = 1'b1;
    repeat (5) step();
    checks++;
    if (mv_cyc.size() != 0 || period !== 7'd7) begin
      errors++; $display("FAIL en_off_idle got %0d meas period %0d want 0 meas period 7", mv_cyc.size(), period);
    end
    $display("test_enable_on_rise done");
  endtask

  task automatic test_reenable();
    enable = 1'b1;
    repeat (3) step();
    sig_in = 1'b0;
    repeat (3) step();
    sig_in = 1'b1;
    repeat (3) step();
    sig_in = 1'b0;
    repeat (2) step();
    checks++;
    if (mv_cyc.size() != 0) begin
      errors++; $display("FAIL reen_first_rise got %0d meas want 0", mv_cyc.size());
    end
    sig_in = 1'b1;
    repeat (3) step();
    checks++;
    if (mv_cyc.size() != 1 || period !== 7'd5 || high_time !== 7'd3) begin
      errors++; $display("FAIL reen_meas got %0d meas %0d/%0d want 1 meas 5/3", mv_cyc.size(), period, high_time);
    end
    $display("test_reenable done");
  endtask

  initial begin
    test_reset();
    test_lock_10_5();
    test_switch_7_4();
    test_period2();
    test_timeout();
    test_reset_mid_high();
    test_enable_on_rise();
    test_reenable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
